y86_seq_core: RTL and testbench
===============================

# y86_seq_core

Parametrised multi-cycle y86-subset processor core: the next-generation sequential core with configurable datapath width, reset vector and retired-instruction counter. Adds a memory wait-state handshake (`bus_ready`) and a clean halt state with status output in place of simulation termination. Sits between the testbench/SoC memory model and the fault-analysis harness; exposes the current opcode for coverage tracking.

## Interface
Parameters:
- `DW`, 32, datapath/register/bus width; legal ≥ 32.
- `RESET_IP`, 0, instruction pointer value after reset.
- `CNT_W`, 16, width of retired-instruction counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `bus_A`  out  DW  memory address.
- `bus_in`  in  DW  read data; instruction word is `bus_in[31:0]`.
- `bus_out`  out  DW  store data.
- `bus_RE`  out  1  read strobe.
- `bus_WE`  out  1  write strobe.
- `bus_ready`  in  1  memory completes the current read/write this cycle.
- `current_opcode`  out  8  IR[7:0].
- `halted`  out  1  core stopped on HALT.
- `retired`  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT (one-hot). Reset → FETCH.
- Decode: opcode=IR[7:0], mod=IR[15:14], RD=IR[10:8], RS=IR[13:11], distance=sext(IR[15:8]), disp=sext(IR[23:16]) to DW.
- ISA: 0x8B mod1 load R[RS]←M[R[6]+disp]; 0x89 mod3 move R[RD]←R[RS]; 0x89 mod1 store M[R[6]+disp]←R[RS]; 0x01 add R[RD]←R[RD]+R[RS]; 0x29 sub R[RD]←R[RD]−R[RS]; 0x75 jnez; 0xF4 halt. Any other opcode: length 1, no state change except IP/retired.
- Length: load/store 3; add/sub/move/jnez 2; others 1.
- FETCH: bus_A=IP, bus_RE=1; on bus_ready IR←bus_in[31:0], → DECODE; else stay.
- DECODE: A←R[memory?6:RD], B←R[RS]. If halt → HALT (IP unchanged, retired+1). Else IP←IP+length+(jnez&&!ZF ? distance : 0), mod 2^DW; → EXEC.
- EXEC: ALUout=A+(memory?disp:(sub?~B:B))+sub, DW bits. MAR←ALUout; C←move?B:ALUout; MDRw←B; ZF←(ALUout==0) only for add/sub. → MEM.
- MEM: load: bus_A=MAR, bus_RE=1, MDRr←bus_in on bus_ready. store: bus_A=MAR, bus_WE=1, bus_out=MDRw. Stay until bus_ready. Non-memory ops pass in one cycle, no strobes. → WB.
- WB: load R[RS]←MDRr; add/sub/move R[RD]←C; retired+1; → FETCH.
- HALT: absorbing; halted=1, no strobes; exit only by reset.
- bus_A=0 and strobes low in DECODE, EXEC, WB, HALT.

## Timing
- Zero-wait throughput: 5 cycles/instruction; each FETCH/MEM wait cycle adds 1.
- Strobes are combinational from state; bus_A/bus_out stable while strobe held waiting.
- bus_ready ignored outside FETCH and MEM-of-load/store.
- Reset (any time, including mid-wait): state=FETCH, IP=RESET_IP, R[0..7]=0, ZF=0, retired=0, halted=0, IR/A/B/MAR/MDRw/MDRr/C=0. After release, bus_RE=1 and bus_A=RESET_IP on the first cycle.
- ZF reflects last add/sub; move/load/store/jnez do not modify it.
- Register writes take effect at end of WB; next instruction's DECODE sees them.

## Test plan
- Reset: rst low mid-MEM-wait → all outputs 0 except bus_RE=1, bus_A=RESET_IP after release; retired=0.
- ALU/flags: R1=5 (via load), R2=5; `sub R1,R2` (0x29, modrm 0xD1) → R1=0, ZF=1; next jnez not taken, IP advances 2.
- Branch: ZF=0, jnez distance 0xFC at IP=0x10 → IP=0x10+2−4=0x0E.
- Memory + waits: R6=0x100, load disp 0x04 with bus_ready low 3 cycles → bus_A=0x104 held 4 cycles, R[RS]=bus_in; instruction takes 8 cycles.
- Store: R6=0x200, RS=3=0xDEADBEEF, disp 0xF8 → bus_WE=1, bus_A=0x1F8, bus_out=0xDEADBEEF.
- Halt: 0xF4 after 3 instructions → halted=1, retired=4, bus strobes stay 0 for 100 cycles; DW=64 run of add program yields 64-bit correct sums.

Source files
------------

// File: rtl/y86_bus_if.sv
// y86_bus_if: memory bus between the sequential core and its memory model.
//   bus_A     address (core -> memory)
//   bus_out   store data (core -> memory)
//   bus_RE    read strobe (core -> memory)
//   bus_WE    write strobe (core -> memory)
//   bus_in    read data; instruction word is bus_in[31:0] (memory -> core)
//   bus_ready memory completes the current read/write this cycle (memory -> core)
interface y86_bus_if #(
   parameter int DW = 32
);
   logic [DW-1:0] bus_A;
   logic [DW-1:0] bus_in;
   logic [DW-1:0] bus_out;
   logic          bus_RE;
   logic          bus_WE;
   logic          bus_ready;

   modport master (
      output bus_A,
      output bus_out,
      output bus_RE,
      output bus_WE,
      input  bus_in,
      input  bus_ready
   );

   modport slave (
      input  bus_A,
      input  bus_out,
      input  bus_RE,
      input  bus_WE,
      output bus_in,
      output bus_ready
   );
endinterface

// File: rtl/y86_seq_core.sv
// y86_seq_core: multi-cycle y86-subset processor with wait-state memory bus,
// HALT state and a retired-instruction counter.
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   bus            y86_bus_if master: bus_A/bus_out/bus_RE/bus_WE out,
//                  bus_in/bus_ready in
//   current_opcode IR[7:0]
//   halted         core stopped on HALT
//   retired        completed instructions, wraps modulo 2^CNT_W
//
// state  | meaning
// FETCH  | read instruction at IP, wait for bus_ready
// DECODE | latch operands, advance IP (or enter HALT)
// EXEC   | ALU, address/result/store-data latches, ZF for add/sub
// MEM    | load/store bus cycle held until bus_ready; others pass through
// WB     | register write-back, retire
// HALT   | absorbing stop, only reset leaves it
module y86_seq_core #(
   parameter int             DW       = 32,
   parameter logic [DW-1:0]  RESET_IP = '0,
   parameter int             CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   y86_bus_if.master        bus,
   output logic [7:0]       current_opcode,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [5:0] {
      FETCH  = 6'b000001,
      DECODE = 6'b000010,
      EXEC   = 6'b000100,
      MEM    = 6'b001000,
      WB     = 6'b010000,
      HALT   = 6'b100000
   } state_t;

   state_t state, state_nxt;

   logic [DW-1:0] ip;
   // Only the low three bytes of the instruction word carry information.
   logic [23:0]   ir;
   logic [DW-1:0] a, b, mar, mdrw, mdrr, c;
   logic          zf;
   logic [DW-1:0] gpr [0:7];

   logic [7:0]    opcode;
   logic [1:0]    mode;
   logic [2:0]    rd, rs;
   logic [DW-1:0] distance, disp;
   logic          op_load, op_store, op_move, op_add, op_sub, op_jnez, op_halt;
   logic          op_mem;
   logic [DW-1:0] ilen, ip_nxt, alu_b, alu_out;

   assign opcode   = ir[7:0];
   assign mode     = ir[15:14];
   assign rd       = ir[10:8];
   assign rs       = ir[13:11];
   assign distance = {{(DW-8){ir[15]}}, ir[15:8]};
   assign disp     = {{(DW-8){ir[23]}}, ir[23:16]};

   assign op_load  = (opcode == 8'h8B) && (mode == 2'd1);
   assign op_store = (opcode == 8'h89) && (mode == 2'd1);
   assign op_move  = (opcode == 8'h89) && (mode == 2'd3);
   assign op_add   = (opcode == 8'h01);
   assign op_sub   = (opcode == 8'h29);
   assign op_jnez  = (opcode == 8'h75);
   assign op_halt  = (opcode == 8'hF4);
   assign op_mem   = op_load || op_store;

   always_comb begin
      ilen = DW'(1);
      if (op_mem)
         ilen = DW'(3);
      else if (op_add || op_sub || op_move || op_jnez)
         ilen = DW'(2);
   end

   assign ip_nxt = ip + ilen + ((op_jnez && !zf) ? distance : '0);

   // Subtract as A + ~B + 1; memory ops use the ALU for base + disp.
   assign alu_b   = op_mem ? disp : (op_sub ? ~b : b);
   assign alu_out = a + alu_b + {{(DW-1){1'b0}}, op_sub};

   assign current_opcode = opcode;
   assign halted         = (state == HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.bus_A   = '0;
      bus.bus_out = '0;
      bus.bus_RE  = 1'b0;
      bus.bus_WE  = 1'b0;
      case (state)
         FETCH: begin
            bus.bus_A  = ip;
            bus.bus_RE = 1'b1;
            if (bus.bus_ready)
               state_nxt = DECODE;
         end
         DECODE: state_nxt = op_halt ? HALT : EXEC;
         EXEC:   state_nxt = MEM;
         MEM: begin
            if (op_load) begin
               bus.bus_A  = mar;
               bus.bus_RE = 1'b1;
               if (bus.bus_ready)
                  state_nxt = WB;
            end else if (op_store) begin
               bus.bus_A   = mar;
               bus.bus_out = mdrw;
               bus.bus_WE  = 1'b1;
               if (bus.bus_ready)
                  state_nxt = WB;
            end else begin
               state_nxt = WB;
            end
         end
         WB:      state_nxt = FETCH;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ip      <= RESET_IP;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         mar     <= '0;
         mdrw    <= '0;
         mdrr    <= '0;
         c       <= '0;
         zf      <= 1'b0;
         retired <= '0;
         for (int i = 0; i < 8; i++)
            gpr[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (bus.bus_ready)
                  ir <= bus.bus_in[23:0];
            end
            DECODE: begin
               a <= gpr[op_mem ? 3'd6 : rd];
               b <= gpr[rs];
               // HALT retires here because it never reaches WB.
               if (op_halt)
                  retired <= retired + CNT_W'(1);
               else
                  ip <= ip_nxt;
            end
            EXEC: begin
               mar  <= alu_out;
               c    <= op_move ? b : alu_out;
               mdrw <= b;
               if (op_add || op_sub)
                  zf <= (alu_out == '0);
            end
            MEM: begin
               if (op_load && bus.bus_ready)
                  mdrr <= bus.bus_in;
            end
            WB: begin
               if (op_load)
                  gpr[rs] <= mdrr;
               else if (op_add || op_sub || op_move)
                  gpr[rd] <= c;
               retired <= retired + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_y86_seq_core.sv
module tb_y86_seq_core;

   logic clk;
   logic rst;
   logic rst64;

   logic [7:0]  opcode32, opcode64;
   logic        halted32, halted64;
   logic [15:0] retired32, retired64;

   logic [31:0] mem32 [0:1023];
   logic [63:0] mem64 [0:127];

   int n_checks = 0;
   int n_fail   = 0;
   int quiet_cnt;

   y86_bus_if #(.DW(32)) bus32 ();
   y86_bus_if #(.DW(64)) bus64 ();

   y86_seq_core #(.DW(32)) dut32 (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus32),
      .current_opcode (opcode32),
      .halted         (halted32),
      .retired        (retired32)
   );

   y86_seq_core #(.DW(64)) dut64 (
      .clk            (clk),
      .rst            (rst64),
      .bus            (bus64),
      .current_opcode (opcode64),
      .halted         (halted64),
      .retired        (retired64)
   );

   assign bus32.bus_in = mem32[bus32.bus_A[9:0]];
   assign bus64.bus_in = mem64[bus64.bus_A[6:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Fetch cycle: read strobe only, address = expected IP.
   task automatic chk_fetch(input string tag, input logic re, input logic we,
                            input logic [63:0] addr, input logic [63:0] exp_ip);
      chk(tag, (re === 1'b1 && we === 1'b0) ? addr : 64'hBAD0_BAD0_BAD0_BAD0, exp_ip);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b0;
      rst64 = 1'b0;
      bus32.bus_ready = 1'b1;
      bus64.bus_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem32[i] = '0;
      for (int i = 0; i < 128; i++)  mem64[i] = '0;

      // 32-bit program
      mem32[10'h000] = 32'h0040708B; // load R6 <- M[R6+0x40]
      mem32[10'h003] = 32'h0004488B; // load R1 <- M[R6+4]   (waits)
      mem32[10'h006] = 32'h0008508B; // load R2 <- M[R6+8]
      mem32[10'h009] = 32'h0000D129; // sub R1,R2 -> 0, ZF=1
      mem32[10'h00B] = 32'h00001075; // jnez +0x10, not taken
      mem32[10'h00D] = 32'h0000D201; // add R2,R2 -> 10, ZF=0
      mem32[10'h00F] = 32'h00000090; // unknown opcode, length 1
      mem32[10'h010] = 32'h0000FC75; // jnez -4, taken -> 0x0E
      mem32[10'h00E] = 32'h000C588B; // load R3 <- M[R6+0x0C]
      mem32[10'h011] = 32'h0010708B; // load R6 <- M[R6+0x10] = 0x200
      mem32[10'h014] = 32'h00F85889; // store M[R6-8] <- R3
      mem32[10'h017] = 32'h00004889; // store M[R6] <- R1
      mem32[10'h01A] = 32'h0000D489; // move R4 <- R2
      mem32[10'h01C] = 32'h00046089; // store M[R6+4] <- R4
      mem32[10'h01F] = 32'h000000F4; // halt
      mem32[10'h040] = 32'h00000100;
      mem32[10'h104] = 32'h00000005;
      mem32[10'h108] = 32'h00000005;
      mem32[10'h10C] = 32'hDEADBEEF;
      mem32[10'h110] = 32'h00000200;

      // 64-bit add program
      mem64[7'h00] = 64'h0040488B;   // load R1 <- M[0x40]
      mem64[7'h03] = 64'h0000C901;   // add R1,R1
      mem64[7'h05] = 64'h00484889;   // store M[0x48] <- R1
      mem64[7'h08] = 64'h000000F4;   // halt
      mem64[7'h40] = 64'h0000_0000_FFFF_FFFF;

      #12;
      chk("rst_strobes", {62'b0, bus32.bus_WE, bus32.bus_RE}, 64'h1);
      chk("rst_addr", bus32.bus_A, 64'h0);
      chk("rst_cnt", {halted32, retired32}, 64'h0);
      chk("rst_opcode", opcode32, 64'h0);

      @(negedge clk) rst = 1'b1;
      #1;
      chk_fetch("fetch_00", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h00);
      step(5);
      chk_fetch("fetch_03", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h03);
      chk("retired_1", retired32, 64'd1);

      // load with three wait cycles: address held four cycles, 8 cycles total
      step(3);
      bus32.bus_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("load_wait_hold", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b1, 1'b0, 32'h104});
         step(1);
      end
      bus32.bus_ready = 1'b1;
      chk("load_wait_last", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b1, 1'b0, 32'h104});
      chk("load_opcode", opcode32, 64'h8B);
      step(2);
      chk_fetch("fetch_06", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h06);

      // one fetch wait cycle
      bus32.bus_ready = 1'b0;
      step(1);
      chk_fetch("fetch_06_wait", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h06);
      bus32.bus_ready = 1'b1;
      step(5);
      chk_fetch("fetch_09", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h09);
      step(5);
      chk_fetch("fetch_0B", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h0B);
      step(5);
      chk_fetch("jnez_not_taken", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h0D);
      step(5);
      chk_fetch("fetch_0F", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h0F);
      step(5);
      chk_fetch("other_len1", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h10);
      step(5);
      chk_fetch("jnez_taken", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h0E);
      step(5);
      chk_fetch("fetch_11", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h11);
      step(5);
      chk_fetch("fetch_14", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h14);

      // store with one wait cycle
      step(3);
      bus32.bus_ready = 1'b0;
      chk("store_addr", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b0, 1'b1, 32'h1F8});
      chk("store_data", bus32.bus_out, 64'hDEADBEEF);
      step(1);
      bus32.bus_ready = 1'b1;
      chk("store_hold_addr", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b0, 1'b1, 32'h1F8});
      chk("store_hold_data", bus32.bus_out, 64'hDEADBEEF);
      step(2);
      chk_fetch("fetch_17", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h17);

      step(3);
      chk("store_r1_addr", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b0, 1'b1, 32'h200});
      chk("sub_result", bus32.bus_out, 64'h0);
      step(2);
      chk_fetch("fetch_1A", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h1A);

      step(3);
      chk("move_mem_idle", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, 64'h0);
      step(2);
      chk_fetch("fetch_1C", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h1C);

      step(3);
      chk("store_r4_addr", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b0, 1'b1, 32'h204});
      chk("add_move_result", bus32.bus_out, 64'hA);
      step(2);
      chk_fetch("fetch_1F", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h1F);

      step(2);
      chk("halted", halted32, 64'h1);
      chk("halt_retired", retired32, 64'd15);
      chk("halt_opcode", opcode32, 64'hF4);
      quiet_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus32.bus_RE !== 1'b0 || bus32.bus_WE !== 1'b0 || bus32.bus_A !== '0)
            quiet_cnt++;
         step(1);
      end
      chk("halt_quiet", quiet_cnt, 64'h0);
      chk("halt_stays", halted32, 64'h1);

      // reset in the middle of a load wait
      @(negedge clk) rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk_fetch("rerun_fetch_00", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h00);
      step(3);
      bus32.bus_ready = 1'b0;
      step(1);
      chk("wait_before_rst", {bus32.bus_RE, bus32.bus_WE, bus32.bus_A}, {1'b1, 1'b0, 32'h40});
      rst = 1'b0;
      #1;
      chk("midrst_strobes", {bus32.bus_WE, bus32.bus_RE, bus32.bus_A}, {1'b0, 1'b1, 32'h0});
      chk("midrst_out", bus32.bus_out, 64'h0);
      chk("midrst_cnt", {opcode32, halted32, retired32}, 64'h0);
      bus32.bus_ready = 1'b1;
      @(negedge clk) rst = 1'b1;
      #1;
      chk_fetch("midrst_fetch_00", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h00);
      step(5);
      chk_fetch("midrst_fetch_03", bus32.bus_RE, bus32.bus_WE, bus32.bus_A, 64'h03);
      chk("midrst_retired", retired32, 64'd1);

      // 64-bit datapath
      @(negedge clk) rst64 = 1'b1;
      #1;
      chk_fetch("w64_fetch_00", bus64.bus_RE, bus64.bus_WE, bus64.bus_A, 64'h00);
      step(13);
      chk("w64_store_addr", {62'b0, bus64.bus_RE, bus64.bus_WE}, 64'h1);
      chk("w64_addr", bus64.bus_A, 64'h48);
      chk("w64_sum", bus64.bus_out, 64'h0000_0001_FFFF_FFFE);
      step(2);
      chk_fetch("w64_fetch_08", bus64.bus_RE, bus64.bus_WE, bus64.bus_A, 64'h08);
      step(2);
      chk("w64_halted", halted64, 64'h1);
      chk("w64_retired", retired64, 64'd4);
      quiet_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus64.bus_RE !== 1'b0 || bus64.bus_WE !== 1'b0 || bus64.bus_A !== '0)
            quiet_cnt++;
         step(1);
      end
      chk("w64_halt_quiet", quiet_cnt, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
